// File: rtl/reg_file_pkg.sv
// Shared configuration for the architectural register file: default sizes,
// the hardwired-zero register index and common scalar types.
package reg_file_pkg;

    localparam int unsigned DEF_ROB_SIZE_WIDTH = 4;
    localparam int unsigned DEF_REG_NUM        = 32;
    localparam int unsigned XLEN               = 32;
    localparam int unsigned REG_IDX_W          = 5;

    typedef logic [XLEN-1:0]      word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_X0 = '0;

endpackage

// File: rtl/reg_file_if.sv
// Issue/commit/lookup bundle between the register file (slave) and the
// RoB/decoder side (master).
interface reg_file_if #(
    parameter int unsigned ROB_SIZE_WIDTH = reg_file_pkg::DEF_ROB_SIZE_WIDTH
);
    logic                      rdy;
    logic                      clear;
    logic [ROB_SIZE_WIDTH-1:0] issue_rob_id;
    logic [4:0]                issue_rd;
    logic [ROB_SIZE_WIDTH-1:0] commit_rob_id;
    logic [4:0]                commit_rd;
    logic [31:0]               commit_value;
    logic [4:0]                rs1;
    logic [4:0]                rs2;
    logic [31:0]               val1;
    logic [31:0]               val2;
    logic                      dep1_busy;
    logic                      dep2_busy;
    logic [ROB_SIZE_WIDTH-1:0] dep1;
    logic [ROB_SIZE_WIDTH-1:0] dep2;
    logic [ROB_SIZE_WIDTH-1:0] get_rob_id1;
    logic [ROB_SIZE_WIDTH-1:0] get_rob_id2;
    logic                      get_ready1;
    logic                      get_ready2;
    logic [31:0]               get_value1;
    logic [31:0]               get_value2;

    modport slave (
        input  rdy, clear, issue_rob_id, issue_rd, commit_rob_id, commit_rd,
               commit_value, rs1, rs2, get_ready1, get_ready2, get_value1,
               get_value2,
        output val1, val2, dep1_busy, dep2_busy, dep1, dep2, get_rob_id1,
               get_rob_id2
    );

    modport master (
        output rdy, clear, issue_rob_id, issue_rd, commit_rob_id, commit_rd,
               commit_value, rs1, rs2, get_ready1, get_ready2, get_value1,
               get_value2,
        input  val1, val2, dep1_busy, dep2_busy, dep1, dep2, get_rob_id1,
               get_rob_id2
    );

endinterface

// File: rtl/reg_file.sv
// Architectural register file with per-register rename status (busy + RoB tag)
// and two combinational operand read ports with commit/RoB forwarding.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int unsigned ROB_SIZE_WIDTH = DEF_ROB_SIZE_WIDTH,
    parameter int unsigned REG_NUM        = DEF_REG_NUM
) (
    input logic       clk,
    input logic       rst_n,
    reg_file_if.slave bus
);

    typedef logic [ROB_SIZE_WIDTH-1:0] tag_t;

    typedef struct packed {
        word_t val;
        logic  busy;
        tag_t  dep;
        tag_t  get_id;
    } rd_res_t;

    word_t   r_regs [REG_NUM];
    logic    r_busy [REG_NUM];
    tag_t    r_tag  [REG_NUM];
    rd_res_t w_rd1;
    rd_res_t w_rd2;

    // Later non-blocking writes win: clear overrides commit's busy release,
    // and issue overrides commit's busy release on the same rd.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
                r_busy[i] <= 1'b0;
                r_tag[i]  <= '0;
            end
        end else if (bus.rdy) begin
            if (bus.commit_rd != REG_X0) begin
                r_regs[bus.commit_rd] <= bus.commit_value;
                if (r_busy[bus.commit_rd] && r_tag[bus.commit_rd] == bus.commit_rob_id)
                    r_busy[bus.commit_rd] <= 1'b0;
            end
            if (bus.clear) begin
                for (int unsigned i = 0; i < REG_NUM; i++) begin
                    r_busy[i] <= 1'b0;
                    r_tag[i]  <= '0;
                end
            end else if (bus.issue_rd != REG_X0) begin
                r_busy[bus.issue_rd] <= 1'b1;
                r_tag[bus.issue_rd]  <= bus.issue_rob_id;
            end
        end
    end

    function automatic rd_res_t read_port(input reg_idx_t rs, input logic ready,
                                          input word_t value);
        rd_res_t res;
        res = '0;
        if (rs == REG_X0) begin
            res = '0;
        end else if (!r_busy[rs]) begin
            res.val = r_regs[rs];
        end else begin
            res.get_id = r_tag[rs];
            if (bus.rdy && bus.commit_rd == rs && bus.commit_rob_id == r_tag[rs])
                res.val = bus.commit_value;
            else if (ready)
                res.val = value;
            else begin
                res.busy = 1'b1;
                res.dep  = r_tag[rs];
            end
        end
        return res;
    endfunction

    always_comb begin
        w_rd1 = read_port(bus.rs1, bus.get_ready1, bus.get_value1);
        w_rd2 = read_port(bus.rs2, bus.get_ready2, bus.get_value2);
    end

    assign bus.val1        = w_rd1.val;
    assign bus.dep1_busy   = w_rd1.busy;
    assign bus.dep1        = w_rd1.dep;
    assign bus.get_rob_id1 = w_rd1.get_id;
    assign bus.val2        = w_rd2.val;
    assign bus.dep2_busy   = w_rd2.busy;
    assign bus.dep2        = w_rd2.dep;
    assign bus.get_rob_id2 = w_rd2.get_id;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: rename, commit, forwarding,
// clear, x0, rdy freeze and asynchronous reset.
module tb_reg_file;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    reg_file_if #(.ROB_SIZE_WIDTH(4)) bus ();

    reg_file #(.ROB_SIZE_WIDTH(4), .REG_NUM(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.issue_rd     = '0;
        bus.issue_rob_id = '0;
        bus.commit_rd    = '0;
        bus.commit_rob_id = '0;
        bus.commit_value = '0;
        bus.clear        = 1'b0;
        bus.get_ready1   = 1'b0;
        bus.get_ready2   = 1'b0;
        bus.get_value1   = '0;
        bus.get_value2   = '0;
    endtask

    task automatic rd1(input string name, input logic [31:0] v, input logic b, input logic [3:0] d);
        chk({name, ".val1"}, bus.val1, v);
        chk({name, ".busy1"}, {31'd0, bus.dep1_busy}, {31'd0, b});
        chk({name, ".dep1"}, {28'd0, bus.dep1}, {28'd0, d});
    endtask

    task automatic rd2(input string name, input logic [31:0] v, input logic b, input logic [3:0] d);
        chk({name, ".val2"}, bus.val2, v);
        chk({name, ".busy2"}, {31'd0, bus.dep2_busy}, {31'd0, b});
        chk({name, ".dep2"}, {28'd0, bus.dep2}, {28'd0, d});
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.rdy = 1'b1;
        bus.rs1 = '0;
        bus.rs2 = '0;
        idle();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // reset state
        bus.rs1 = 5'd5; bus.rs2 = 5'd0; #1;
        rd1("reset", 32'h0, 1'b0, 4'd0);
        rd2("reset", 32'h0, 1'b0, 4'd0);

        // rename x3 -> tag 2
        bus.issue_rd = 5'd3; bus.issue_rob_id = 4'd2;
        tick(); idle();
        bus.rs1 = 5'd3; #1;
        rd1("dep_x3", 32'h0, 1'b1, 4'd2);
        chk("dep_x3.getid1", {28'd0, bus.get_rob_id1}, 32'd2);

        // RoB forwarding
        bus.get_ready1 = 1'b1; bus.get_value1 = 32'hDEAD; #1;
        rd1("rob_fwd", 32'hDEAD, 1'b0, 4'd0);
        chk("rob_fwd.getid1", {28'd0, bus.get_rob_id1}, 32'd2);

        // commit forwarding then architectural value
        idle();
        bus.commit_rd = 5'd3; bus.commit_rob_id = 4'd2; bus.commit_value = 32'h1234; #1;
        rd1("commit_fwd", 32'h1234, 1'b0, 4'd0);
        tick(); idle(); #1;
        rd1("after_commit", 32'h1234, 1'b0, 4'd0);
        chk("after_commit.getid1", {28'd0, bus.get_rob_id1}, 32'd0);

        // stale commit leaves newer rename
        bus.issue_rd = 5'd3; bus.issue_rob_id = 4'd5;
        tick(); idle();
        bus.commit_rd = 5'd3; bus.commit_rob_id = 4'd2; bus.commit_value = 32'd7; #1;
        rd1("stale_during", 32'h0, 1'b1, 4'd5);
        tick(); idle(); #1;
        rd1("stale_after", 32'h0, 1'b1, 4'd5);

        // issue + commit same rd: write lands, issue keeps busy with new tag
        bus.issue_rd = 5'd9; bus.issue_rob_id = 4'd4;
        tick(); idle();
        bus.commit_rd = 5'd9; bus.commit_rob_id = 4'd4; bus.commit_value = 32'hAA;
        bus.issue_rd = 5'd9; bus.issue_rob_id = 4'd6;
        tick(); idle();
        bus.rs1 = 5'd9; #1;
        rd1("iss_cmt_same", 32'h0, 1'b1, 4'd6);

        // x4 tag 1, x6 tag 0 (legal), x13 tag 15
        bus.issue_rd = 5'd4; bus.issue_rob_id = 4'd1;
        tick();
        bus.issue_rd = 5'd6; bus.issue_rob_id = 4'd0;
        tick();
        bus.issue_rd = 5'd13; bus.issue_rob_id = 4'd15;
        tick(); idle();
        bus.rs1 = 5'd4; bus.rs2 = 5'd6; #1;
        rd1("busy_x4", 32'h0, 1'b1, 4'd1);
        rd2("busy_x6_tag0", 32'h0, 1'b1, 4'd0);
        bus.rs2 = 5'd13; #1;
        rd2("busy_x13_tag15", 32'h0, 1'b1, 4'd15);

        // clear with issue to x8 and commit to x10
        bus.clear = 1'b1; bus.issue_rd = 5'd8; bus.issue_rob_id = 4'd3;
        bus.commit_rd = 5'd10; bus.commit_rob_id = 4'd9; bus.commit_value = 32'h77;
        tick(); idle();
        bus.rs1 = 5'd3; bus.rs2 = 5'd4; #1;
        rd1("clr_x3", 32'd7, 1'b0, 4'd0);
        rd2("clr_x4", 32'h0, 1'b0, 4'd0);
        bus.rs1 = 5'd6; bus.rs2 = 5'd8; #1;
        rd1("clr_x6", 32'h0, 1'b0, 4'd0);
        rd2("clr_x8", 32'h0, 1'b0, 4'd0);
        bus.rs1 = 5'd9; bus.rs2 = 5'd10; #1;
        rd1("clr_x9", 32'hAA, 1'b0, 4'd0);
        rd2("clr_x10", 32'h77, 1'b0, 4'd0);

        // x0 ignores issue and commit
        bus.issue_rd = 5'd0; bus.issue_rob_id = 4'd7;
        bus.commit_rd = 5'd0; bus.commit_value = 32'hFFFF;
        bus.rs1 = 5'd0; bus.rs2 = 5'd0; #1;
        rd1("x0_during", 32'h0, 1'b0, 4'd0);
        tick(); idle(); #1;
        rd1("x0_after", 32'h0, 1'b0, 4'd0);

        // rdy low freezes everything
        bus.rdy = 1'b0;
        bus.issue_rd = 5'd11; bus.issue_rob_id = 4'd2;
        bus.commit_rd = 5'd12; bus.commit_rob_id = 4'd0; bus.commit_value = 32'h99;
        tick(); idle();
        tick();
        bus.rdy = 1'b1;
        bus.rs1 = 5'd11; bus.rs2 = 5'd12; #1;
        rd1("frz_x11", 32'h0, 1'b0, 4'd0);
        rd2("frz_x12", 32'h0, 1'b0, 4'd0);

        // asynchronous reset mid-operation
        bus.issue_rd = 5'd14; bus.issue_rob_id = 4'd3;
        tick(); idle();
        bus.rs1 = 5'd14; bus.rs2 = 5'd3; #1;
        rd1("pre_rst_x14", 32'h0, 1'b1, 4'd3);
        rd2("pre_rst_x3", 32'd7, 1'b0, 4'd0);
        #1 rst_n = 1'b0; #1;
        rd1("rst_x14", 32'h0, 1'b0, 4'd0);
        rd2("rst_x3", 32'h0, 1'b0, 4'd0);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
